// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU bus definitions: UART window addresses, status bit layout, serial port FSM states.
package cpu_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LOW,
    S_WR_LOW,
    S_WR_WAIT_TBRE,
    S_WR_WAIT_TSRE,
    S_DONE
  } sp_state_t;
  localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
  localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;
  localparam int STAT_WR_READY = 0;
  localparam int STAT_RD_READY = 1;
endpackage

// File: rtl/serial_port_controller.sv
// serial_port_controller: turns single-cycle CPU requests on the UART window into timed rdn/wrn strobes.
module serial_port_controller
  import cpu_pkg::*;
#(
  parameter int unsigned RD_PULSE  = 2,
  parameter int unsigned WR_PULSE  = 2,
  parameter logic [15:0] DATA_ADDR = UART_DATA_ADDR,
  parameter logic [15:0] STAT_ADDR = UART_STAT_ADDR
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        reqRead,
  input  logic        reqWrite,
  input  logic [15:0] address,
  input  logic [15:0] dataIn,
  output logic [15:0] dataOut,
  output logic        busy,
  output logic        done,
  input  logic [7:0]  uartDataIn,
  output logic [7:0]  uartDataOut,
  output logic        uartDataOE,
  input  logic        data_ready,
  input  logic        tbre,
  input  logic        tsre,
  output logic        rdn,
  output logic        wrn
);
  sp_state_t   r_state, w_nxt;
  logic [3:0]  r_cnt, w_cnt;
  logic [15:0] r_dout, w_dout, w_status;
  logic [7:0]  r_uout, w_uout;
  logic        r_oe, w_oe;
  logic        w_data_hit, w_in_win, w_unused;
  assign w_data_hit = address == DATA_ADDR;
  assign w_in_win   = w_data_hit || address == STAT_ADDR;
  assign w_unused   = ^dataIn[15:8];
  always_comb begin
    w_status = '0;
    w_status[STAT_RD_READY] = data_ready;
    w_status[STAT_WR_READY] = tbre & tsre;
  end
  always_comb begin
    w_nxt  = r_state;
    w_cnt  = r_cnt == 4'd0 ? 4'd0 : 4'(r_cnt - 4'd1);
    w_dout = r_dout;
    w_uout = r_uout;
    w_oe   = r_oe;
    case (r_state)
      S_IDLE: begin
        if (reqWrite) begin
          w_nxt  = w_data_hit ? S_WR_LOW : S_DONE;
          w_cnt  = 4'(WR_PULSE - 1);
          w_uout = w_data_hit ? dataIn[7:0] : r_uout;
          w_oe   = w_data_hit;
          w_dout = w_in_win ? r_dout : '0;
        end else if (reqRead) begin
          w_nxt  = w_data_hit ? S_RD_LOW : S_DONE;
          w_cnt  = 4'(RD_PULSE - 1);
          w_dout = address == STAT_ADDR ? w_status : w_data_hit ? r_dout : '0;
        end
      end
      S_RD_LOW: begin
        w_nxt  = r_cnt == 4'd0 ? S_DONE : S_RD_LOW;
        w_dout = r_cnt == 4'd0 ? {8'h00, uartDataIn} : r_dout;
      end
      S_WR_LOW: w_nxt = r_cnt == 4'd0 ? S_WR_WAIT_TBRE : S_WR_LOW;
      // Bus stays driven for one cycle after wrn rises to give the UART hold time.
      S_WR_WAIT_TBRE: begin
        w_oe  = 1'b0;
        w_nxt = tbre ? S_WR_WAIT_TSRE : S_WR_WAIT_TBRE;
      end
      S_WR_WAIT_TSRE: w_nxt = tsre ? S_DONE : S_WR_WAIT_TSRE;
      default: w_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_uout  <= '0;
      r_oe    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt;
      r_dout  <= w_dout;
      r_uout  <= w_uout;
      r_oe    <= w_oe;
    end
  end
  assign rdn         = r_state != S_RD_LOW;
  assign wrn         = r_state != S_WR_LOW;
  assign done        = r_state == S_DONE;
  assign busy        = r_state != S_IDLE && r_state != S_DONE;
  assign dataOut     = r_dout;
  assign uartDataOut = r_uout;
  assign uartDataOE  = r_oe;
endmodule

// File: tb/tb_serial_port_controller.sv
// tb_serial_port_controller: vector table, corner-case sequences and random traffic against a latency/data model.
module tb_serial_port_controller;
  localparam int RP = 2;
  localparam int WP = 2;
  localparam logic [15:0] DA = 16'hBF00;
  localparam logic [15:0] SA = 16'hBF01;
  typedef struct {
    logic        rd, wr;
    logic [15:0] addr, din;
    logic [7:0]  uin;
    logic        dr, tb, ts;
    int          tdel, sdel;
    int          lat, rdl, wrl;
    logic [15:0] dout;
  } vec_t;
  logic        CLK, RST, reqRead, reqWrite, busy, done, uartDataOE, data_ready, tbre, tsre, rdn, wrn;
  logic [15:0] address, dataIn, dataOut;
  logic [7:0]  uartDataIn, uartDataOut;
  int          n_chk = 0, n_fail = 0;
  logic [15:0] last_dout;
  serial_port_controller #(.RD_PULSE(RP), .WR_PULSE(WP)) dut (
    .CLK(CLK), .RST(RST), .reqRead(reqRead), .reqWrite(reqWrite), .address(address),
    .dataIn(dataIn), .dataOut(dataOut), .busy(busy), .done(done), .uartDataIn(uartDataIn),
    .uartDataOut(uartDataOut), .uartDataOE(uartDataOE), .data_ready(data_ready), .tbre(tbre),
    .tsre(tsre), .rdn(rdn), .wrn(wrn)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic rd, wr, input logic [15:0] addr, din, input logic [7:0] uin,
                              input logic dr, tb, ts, input int tdel, sdel, lat, rdl, wrl,
                              input logic [15:0] dout);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.din = din; v.uin = uin; v.dr = dr; v.tb = tb; v.ts = ts;
    v.tdel = tdel; v.sdel = sdel; v.lat = lat; v.rdl = rdl; v.wrl = wrl; v.dout = dout;
    return v;
  endfunction
  // Reference: latency and result derived from the access rules, not from the FSM.
  function automatic vec_t model(input vec_t v, input logic [15:0] prev);
    vec_t m = v;
    m.rdl = 0; m.wrl = 0; m.lat = 1; m.dout = prev;
    if (v.wr) begin
      if (v.addr == DA) begin
        m.wrl = WP;
        m.lat = WP + 2 + v.tdel + (v.sdel > 1 ? v.sdel : 1);
      end else if (v.addr != SA) m.dout = 16'h0;
    end else if (v.addr == SA) m.dout = {14'h0, v.dr, v.tb & v.ts};
    else if (v.addr == DA) begin
      m.rdl = RP; m.lat = RP + 1; m.dout = {8'h00, v.uin};
    end else m.dout = 16'h0;
    return m;
  endfunction
  task automatic txn(input vec_t v, output int lat, rdl, wrl, oe, bsy, uok, viol, output logic [15:0] d);
    bit wrop, seen_wr;
    int m;
    wrop = v.wr && v.addr == DA;
    seen_wr = 0; m = -1;
    lat = -1; rdl = 0; wrl = 0; oe = 0; bsy = 0; uok = 0; viol = 0; d = 'x;
    @(negedge CLK);
    reqRead = v.rd; reqWrite = v.wr; address = v.addr; dataIn = v.din; uartDataIn = v.uin;
    data_ready = v.dr; tbre = wrop ? 1'b0 : v.tb; tsre = wrop ? 1'b0 : v.ts;
    for (int n = 1; n <= 200; n++) begin
      @(negedge CLK);
      reqRead = 1'b0; reqWrite = 1'b0;
      if (!rdn) rdl++;
      if (!wrn) begin
        wrl++; seen_wr = 1;
        if (uartDataOut == v.din[7:0] && uartDataOE) uok++;
      end
      if (uartDataOE) oe++;
      if (busy) bsy++;
      if ((!rdn && !wrn) || (uartDataOE && !rdn)) viol++;
      if (wrop && seen_wr && wrn && m < 0) m = n;
      if (m >= 0 && n == m + v.tdel) tbre = 1'b1;
      if (m >= 0 && n == m + v.tdel + v.sdel) tsre = 1'b1;
      if (done) begin
        lat = n; d = dataOut;
        break;
      end
    end
  endtask
  task automatic run(input vec_t v);
    int lat, rdl, wrl, oe, bsy, uok, viol;
    logic [15:0] d;
    txn(v, lat, rdl, wrl, oe, bsy, uok, viol, d);
    chk("latency", lat, v.lat);
    chk("dataOut", {16'h0, d}, {16'h0, v.dout});
    chk("rdn_low_cycles", rdl, v.rdl);
    chk("wrn_low_cycles", wrl, v.wrl);
    chk("oe_cycles", oe, v.wrl != 0 ? v.wrl + 1 : 0);
    chk("busy_cycles", bsy, v.lat - 1);
    chk("wr_data_driven", uok, v.wrl);
    chk("strobe_exclusion", viol, 0);
    last_dout = v.dout;
  endtask
  initial begin
    vec_t vt[10];
    vec_t v;
    int dn, rl, dc;
    vt[0] = mk(1, 0, SA, 16'h0, 8'h00, 1, 1, 0, 0, 0, 1, 0, 0, 16'h0002);
    vt[1] = mk(1, 0, DA, 16'h0, 8'hA5, 0, 0, 0, 0, 0, 3, 2, 0, 16'h00A5);
    vt[2] = mk(0, 1, DA, 16'h1234, 8'h00, 0, 0, 0, 5, 3, 12, 0, 2, 16'h00A5);
    vt[3] = mk(1, 1, DA, 16'h00FF, 8'h11, 0, 0, 0, 0, 0, 5, 0, 2, 16'h00A5);
    vt[4] = mk(1, 0, 16'h8000, 16'h0, 8'h77, 1, 1, 1, 0, 0, 1, 0, 0, 16'h0000);
    vt[5] = mk(1, 0, SA, 16'h0, 8'h00, 0, 1, 1, 0, 0, 1, 0, 0, 16'h0001);
    vt[6] = mk(1, 0, SA, 16'h0, 8'h00, 1, 1, 1, 0, 0, 1, 0, 0, 16'h0003);
    vt[7] = mk(1, 0, DA, 16'h0, 8'h5A, 0, 0, 0, 0, 0, 3, 2, 0, 16'h005A);
    vt[8] = mk(0, 1, DA, 16'hABCD, 8'h00, 0, 0, 0, 1, 0, 6, 0, 2, 16'h005A);
    vt[9] = mk(1, 0, 16'h8000, 16'h0, 8'h33, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000);
    RST = 1'b0; reqRead = 0; reqWrite = 0; address = 0; dataIn = 0; uartDataIn = 0;
    data_ready = 0; tbre = 0; tsre = 0;
    repeat (3) @(negedge CLK);
    chk("reset_rdn", rdn, 1); chk("reset_wrn", wrn, 1); chk("reset_oe", uartDataOE, 0);
    chk("reset_uout", uartDataOut, 0); chk("reset_dout", dataOut, 0);
    chk("reset_busy", busy, 0); chk("reset_done", done, 0);
    RST = 1'b1;
    foreach (vt[i]) run(vt[i]);
    // A read issued while a write is in flight must be ignored.
    @(negedge CLK);
    reqWrite = 1; address = DA; dataIn = 16'h0077; tbre = 0; tsre = 0;
    dn = 0; rl = 0; dc = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge CLK);
      reqWrite = 0; reqRead = n == 2;
      if (n == 6) begin tbre = 1; tsre = 1; end
      if (!rdn) rl++;
      if (done) begin dn++; dc = n; end
    end
    reqRead = 0;
    chk("busy_read_dones", dn, 1); chk("busy_read_rdn_low", rl, 0); chk("busy_read_done_cycle", dc, 8);
    chk("busy_read_dout_kept", dataOut, last_dout);
    // Reset during the first wrn-low cycle.
    @(negedge CLK);
    reqWrite = 1; address = DA; dataIn = 16'h00C3; tbre = 0; tsre = 0;
    @(negedge CLK);
    reqWrite = 0;
    chk("pre_reset_wrn", wrn, 0); chk("pre_reset_oe", uartDataOE, 1);
    RST = 1'b0;
    #1;
    chk("async_reset_wrn", wrn, 1); chk("async_reset_oe", uartDataOE, 0);
    chk("async_reset_busy", busy, 0); chk("async_reset_rdn", rdn, 1);
    tbre = 1; tsre = 1; dn = 0;
    repeat (4) @(negedge CLK) if (done) dn++;
    RST = 1'b1;
    repeat (3) @(negedge CLK) if (done) dn++;
    chk("reset_no_done", dn, 0); chk("reset_dout_cleared", dataOut, 0);
    run(mk(1, 0, SA, 16'h0, 8'h00, 0, 1, 1, 0, 0, 1, 0, 0, 16'h0001));
    for (int k = 0; k < 40; k++) begin
      int kind, ak;
      kind = $urandom_range(0, 2);
      ak = $urandom_range(0, 3);
      v = mk(kind != 1, kind != 0, ak == 0 ? 16'h8000 + 16'($urandom_range(0, 255)) : ak == 1 ? SA : DA,
             16'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 6), $urandom_range(0, 4), 0, 0, 0, 16'h0);
      run(model(v, last_dout));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_port_controller.md
Name: serial_port_controller

Overview:
- Downstream of the memory controller on the shared ram1 data bus; services CPU accesses to the UART window (0xBF00 data, 0xBF01 status).
- Converts a single-cycle read/write request into correctly timed rdn/wrn strobes with data_ready/tbre/tsre handshakes, then returns data and a done pulse.
- The memory controller routes UART-window addresses here and tri-states SRAM (ram1EN high) while busy is high.

Parameters:
- RD_PULSE, 2, cycles rdn is held low; data is sampled on the last low cycle (1..15).
- WR_PULSE, 2, cycles wrn is held low with data driven (1..15).
- DATA_ADDR, 16'hBF00, UART data register address.
- STAT_ADDR, 16'hBF01, UART status register address.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- reqRead  input  1  one-cycle read request; sampled only in IDLE.
- reqWrite  input  1  one-cycle write request; sampled only in IDLE.
- address  input  16  access address, sampled with the request.
- dataIn  input  16  write data; bits [7:0] are sent.
- dataOut  output  16  read result; valid from the done cycle until the next done.
- busy  output  1  high from the cycle after an accepted request until done.
- done  output  1  one-cycle completion pulse.
- uartDataIn  input  8  ram1Data[7:0] as seen on the bus.
- uartDataOut  output  8  byte to drive onto ram1Data[7:0].
- uartDataOE  output  1  1 = drive uartDataOut onto the bus.
- data_ready  input  1  UART has a received byte.
- tbre  input  1  transmit buffer empty.
- tsre  input  1  transmit shift register empty.
- rdn  output  1  UART read strobe, active low.
- wrn  output  1  UART write strobe, active low.

Behaviour:
- Reset values (asynchronous): rdn=1, wrn=1, uartDataOE=0, uartDataOut=0, dataOut=0, busy=0, done=0, state IDLE, counter 0.
- States: IDLE, RD_LOW, WR_LOW, WR_WAIT_TBRE, WR_WAIT_TSRE, DONE.
- IDLE request decode:
  - reqWrite and reqRead both high: write wins; the read is dropped.
  - Requests while not in IDLE are ignored. The upstream block must hold off until done.
  - address not DATA_ADDR/STAT_ADDR: done pulses the next cycle, dataOut=0, no strobe.
- Status read (STAT_ADDR):
  - No bus activity; next cycle DONE.
  - dataOut = {14'b0, data_ready, tbre & tsre}, sampled in the request cycle.
  - Latency 1 cycle (done on the cycle after the request).
- Data read (DATA_ADDR):
  - IDLE -> RD_LOW: rdn=0 for RD_PULSE cycles.
  - On the last RD_LOW cycle, dataOut <= {8'b0, uartDataIn}; rdn returns to 1 on entering DONE.
  - No data_ready check; software polls status first.
  - Latency RD_PULSE+1.
- Data write (DATA_ADDR):
  - IDLE -> WR_LOW: uartDataOut <= dataIn[7:0] and uartDataOE=1 from the first WR_LOW cycle; wrn=0 for WR_PULSE cycles.
  - wrn rises first. uartDataOE drops one cycle later, in WR_WAIT_TBRE, to give hold time.
  - WR_WAIT_TBRE waits for tbre=1, then WR_WAIT_TSRE waits for tsre=1, then DONE. Either wait may be 0 cycles if the flag is already high.
  - No timeout; busy stays high while waiting.
  - dataOut is unchanged on writes.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. A new request in the cycle after DONE is accepted.
- Counter: 4-bit, loaded with PULSE-1 on state entry, decrements to 0, no wrap.
- Reset mid-operation: all strobes deassert immediately (asynchronous), the bus is released, no done pulse is issued, and the in-flight access is lost.
- rdn and wrn are never both low. uartDataOE is never 1 while rdn=0.

Decomposition:
- Shared package cpu_pkg:
  - state encoding localparams.
  - UART_DATA_ADDR / UART_STAT_ADDR constants (also used by the memory controller's address decode).
  - Status bit positions: STAT_WR_READY=0, STAT_RD_READY=1.
- A single module. No sub-module is needed; the pulse counter is inline.

Test Plan:
- Status read: data_ready=1, tbre=1, tsre=0, reqRead at 0xBF01 -> done next cycle, dataOut=16'h0002, rdn/wrn stay 1.
- Data read: uartDataIn=8'hA5, reqRead at 0xBF00 -> rdn low exactly 2 cycles, done on cycle 3, dataOut=16'h00A5.
- Data write: dataIn=16'h1234, tbre rises 5 cycles after wrn rises, tsre 3 cycles after that -> wrn low 2 cycles with uartDataOut=8'h34 and OE=1, OE drops one cycle after wrn rises, done exactly 1 cycle after tsre=1.
- Simultaneous reqRead+reqWrite at 0xBF00 -> write sequence only, rdn never low; a reqRead issued while busy is ignored (no second done).
- Reset asserted in the 1st WR_LOW cycle -> wrn=1 and OE=0 within the same cycle, no done; after release, a status read works normally.
- Out-of-window address 0x8000 read -> done next cycle, dataOut=0, no strobes.
